// File: rtl/controle_partida.sv
// Pong match control: serve/point pauses, score keeping, end-of-game detection.
// Optional CONTROLE_PARTIDA_VANTAGEM_EN: a player must lead by two to win, or reach 15.
module controle_partida #(
  parameter int PONTOS_VITORIA = 5,
  parameter int PAUSA_CICLOS   = 25000000
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       gol_esq,
  input  logic       gol_dir,
  output logic       running,
  output logic       reset_bola,
  output logic       sentido_saque,
  output logic [3:0] placar_esq,
  output logic [3:0] placar_dir,
  output logic       fim_de_jogo,
  output logic       vencedor,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    SAQUE  = 3'd1,
    JOGO   = 3'd2,
    PONTO  = 3'd3,
    FIM    = 3'd4
  } estado_t;

  localparam logic [31:0] ULTIMO = 32'(PAUSA_CICLOS - 1);
  localparam logic [3:0]  ALVO   = 4'(PONTOS_VITORIA);

  estado_t     estado_q;
  logic [31:0] cont_q;
  logic        start_q;
  logic [3:0]  pe_q, pd_q;
  logic        rb_q, sent_q, fim_q, venc_q;

  logic       start_ev;
  logic [3:0] pe_inc, pd_inc;
  logic       vence_esq, vence_dir;

  assign start_ev = start & ~start_q;

  // Scores saturate at 15 instead of wrapping.
  assign pe_inc = (pe_q == 4'd15) ? 4'd15 : pe_q + 4'd1;
  assign pd_inc = (pd_q == 4'd15) ? 4'd15 : pd_q + 4'd1;

`ifdef CONTROLE_PARTIDA_VANTAGEM_EN
  assign vence_esq = (pe_inc == 4'd15) ||
                     ((pe_inc >= ALVO) && ({1'b0, pe_inc} >= ({1'b0, pd_q} + 5'd2)));
  assign vence_dir = (pd_inc == 4'd15) ||
                     ((pd_inc >= ALVO) && ({1'b0, pd_inc} >= ({1'b0, pe_q} + 5'd2)));
`else
  assign vence_esq = (pe_inc == ALVO);
  assign vence_dir = (pd_inc == ALVO);
`endif

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
      cont_q   <= 32'd0;
      start_q  <= 1'b0;
      pe_q     <= 4'd0;
      pd_q     <= 4'd0;
      rb_q     <= 1'b0;
      sent_q   <= 1'b1;
      fim_q    <= 1'b0;
      venc_q   <= 1'b0;
    end else begin
      start_q <= start;
      rb_q    <= 1'b0;
      fim_q   <= 1'b0;
      case (estado_q)
        OCIOSO, FIM: begin
          if (start_ev) begin
            estado_q <= SAQUE;
            pe_q     <= 4'd0;
            pd_q     <= 4'd0;
            sent_q   <= 1'b1;
            rb_q     <= 1'b1;
            cont_q   <= 32'd0;
          end
        end
        SAQUE, PONTO: begin
          if (cont_q == ULTIMO) begin
            estado_q <= JOGO;
            cont_q   <= 32'd0;
          end else begin
            cont_q <= cont_q + 32'd1;
          end
        end
        JOGO: begin
          // A simultaneous pair of goals credits the right player only.
          if (gol_esq) begin
            pd_q   <= pd_inc;
            sent_q <= 1'b0;
            rb_q   <= 1'b1;
            if (vence_dir) begin
              estado_q <= FIM;
              fim_q    <= 1'b1;
              venc_q   <= 1'b1;
            end else begin
              estado_q <= PONTO;
              cont_q   <= 32'd0;
            end
          end else if (gol_dir) begin
            pe_q   <= pe_inc;
            sent_q <= 1'b1;
            rb_q   <= 1'b1;
            if (vence_esq) begin
              estado_q <= FIM;
              fim_q    <= 1'b1;
              venc_q   <= 1'b0;
            end else begin
              estado_q <= PONTO;
              cont_q   <= 32'd0;
            end
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign running       = (estado_q == JOGO);
  assign reset_bola    = rb_q;
  assign sentido_saque = sent_q;
  assign placar_esq    = pe_q;
  assign placar_dir    = pd_q;
  assign fim_de_jogo   = fim_q;
  assign vencedor      = venc_q;
  assign estado        = estado_q;

endmodule

// File: tb/tb_controle_partida.sv
// Bench for controle_partida with PONTOS_VITORIA=3, PAUSA_CICLOS=4.
module tb_controle_partida;

  logic       VGA_CLK = 1'b0;
  logic       reset   = 1'b1;
  logic       start   = 1'b0;
  logic       gol_esq = 1'b0;
  logic       gol_dir = 1'b0;
  logic       running, reset_bola, sentido_saque, fim_de_jogo, vencedor;
  logic [3:0] placar_esq, placar_dir;
  logic [2:0] estado;

  int ntests = 0;
  int nfail  = 0;

  typedef struct packed {
    logic [2:0] est;
    logic [3:0] pe;
    logic [3:0] pd;
    logic       run;
    logic       rb;
    logic       sent;
    logic       fim;
    logic       venc;
  } obs_t;

  obs_t  exp_q[$];
  string nm_q[$];

  controle_partida #(.PONTOS_VITORIA(3), .PAUSA_CICLOS(4)) dut (
    .VGA_CLK(VGA_CLK), .reset(reset), .start(start),
    .gol_esq(gol_esq), .gol_dir(gol_dir),
    .running(running), .reset_bola(reset_bola), .sentido_saque(sentido_saque),
    .placar_esq(placar_esq), .placar_dir(placar_dir),
    .fim_de_jogo(fim_de_jogo), .vencedor(vencedor), .estado(estado)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  function automatic obs_t mk(input int est, input int pe, input int pd, input bit run,
                              input bit rb, input bit sent, input bit fim, input bit venc);
    obs_t o;
    o.est = 3'(est); o.pe = 4'(pe); o.pd = 4'(pd);
    o.run = run; o.rb = rb; o.sent = sent; o.fim = fim; o.venc = venc;
    return o;
  endfunction

  function automatic obs_t sample();
    return {estado, placar_esq, placar_dir, running, reset_bola, sentido_saque, fim_de_jogo, vencedor};
  endfunction

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic begin_match();
    reset = 1'b1; start = 1'b0; gol_esq = 1'b0; gol_dir = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
  endtask

  task automatic goal_and_wait(input logic ge, input logic gd);
    gol_esq = ge; gol_dir = gd;
    tick();
    gol_esq = 1'b0; gol_dir = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    obs_t e, o;
    string n;
    reset = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0)); nm_q.push_back("reset_held");
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0)); nm_q.push_back("reset_released");
    for (int i = 0; i < 2; i++) begin
      tick();
      if (i == 0) reset = 1'b0;
      e = exp_q.pop_front(); n = nm_q.pop_front(); o = sample(); ntests++;
      if (o !== e) begin nfail++; $display("FAIL %s: got %h want %h", n, o, e); end
    end
  endtask

  task automatic test_start_serve();
    obs_t e, o;
    string n;
    start = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0)); nm_q.push_back("serve_enter");
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0)); nm_q.push_back("serve_pause");
    end
    exp_q.push_back(mk(2, 0, 0, 1, 0, 1, 0, 0)); nm_q.push_back("serve_to_jogo");
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b0;
      e = exp_q.pop_front(); n = nm_q.pop_front(); o = sample(); ntests++;
      if (o !== e) begin nfail++; $display("FAIL %s[%0d]: got %h want %h", n, i, o, e); end
    end
  endtask

  task automatic test_goal_dir();
    obs_t e, o;
    string n;
    gol_dir = 1'b1;
    exp_q.push_back(mk(3, 1, 0, 0, 1, 1, 0, 0)); nm_q.push_back("gol_dir_score");
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(3, 1, 0, 0, 0, 1, 0, 0)); nm_q.push_back("ponto_pause");
    end
    exp_q.push_back(mk(2, 1, 0, 1, 0, 1, 0, 0)); nm_q.push_back("ponto_to_jogo");
    for (int i = 0; i < 5; i++) begin
      tick();
      gol_dir = 1'b0;
      e = exp_q.pop_front(); n = nm_q.pop_front(); o = sample(); ntests++;
      if (o !== e) begin nfail++; $display("FAIL %s[%0d]: got %h want %h", n, i, o, e); end
    end
  endtask

  task automatic test_simultaneous();
    obs_t e, o;
    string n;
    gol_esq = 1'b1; gol_dir = 1'b1;
    exp_q.push_back(mk(3, 1, 1, 0, 1, 0, 0, 0)); nm_q.push_back("both_goals");
    tick();
    gol_esq = 1'b0; gol_dir = 1'b0;
    e = exp_q.pop_front(); n = nm_q.pop_front(); o = sample(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL %s: got %h want %h", n, o, e); end
    exp_q.push_back(mk(2, 1, 1, 1, 0, 0, 0, 0)); nm_q.push_back("both_back_jogo");
    repeat (4) tick();
    e = exp_q.pop_front(); n = nm_q.pop_front(); o = sample(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL %s: got %h want %h", n, o, e); end
  endtask

  task automatic test_win();
    obs_t e, o;
    string n;
    begin_match();
    goal_and_wait(1'b1, 1'b0);
    goal_and_wait(1'b1, 1'b0);
    exp_q.push_back(mk(4, 0, 3, 0, 1, 0, 1, 1)); nm_q.push_back("win_enter_fim");
    exp_q.push_back(mk(4, 0, 3, 0, 0, 0, 0, 1)); nm_q.push_back("fim_pulse_end");
    exp_q.push_back(mk(4, 0, 3, 0, 0, 0, 0, 1)); nm_q.push_back("fim_gol_esq_ignored");
    exp_q.push_back(mk(4, 0, 3, 0, 0, 0, 0, 1)); nm_q.push_back("fim_gol_dir_ignored");
    exp_q.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1)); nm_q.push_back("fim_restart");
    for (int i = 0; i < 5; i++) begin
      gol_esq = (i == 0 || i == 2);
      gol_dir = (i == 3);
      start   = (i == 4);
      tick();
      e = exp_q.pop_front(); n = nm_q.pop_front(); o = sample(); ntests++;
      if (o !== e) begin nfail++; $display("FAIL %s: got %h want %h", n, o, e); end
    end
    gol_esq = 1'b0; gol_dir = 1'b0; start = 1'b0;
  endtask

  task automatic test_goal_ignored();
    obs_t e, o;
    string n;
    int rb_cnt, saque_cnt;
    logic [2:0] prev;
    // Entered SAQUE on the previous edge; a goal here must not score.
    gol_dir = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1)); nm_q.push_back("saque_gol_ignored");
    tick();
    gol_dir = 1'b0;
    e = exp_q.pop_front(); n = nm_q.pop_front(); o = sample(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL %s: got %h want %h", n, o, e); end
    repeat (3) tick();
    gol_dir = 1'b1;
    tick();
    gol_esq = 1'b1; gol_dir = 1'b0;
    exp_q.push_back(mk(3, 1, 0, 0, 0, 1, 0, 1)); nm_q.push_back("ponto_gol_ignored");
    tick();
    gol_esq = 1'b0;
    e = exp_q.pop_front(); n = nm_q.pop_front(); o = sample(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL %s: got %h want %h", n, o, e); end
    exp_q.push_back(mk(2, 1, 0, 1, 0, 1, 0, 1)); nm_q.push_back("ponto_gol_back_jogo");
    repeat (3) tick();
    e = exp_q.pop_front(); n = nm_q.pop_front(); o = sample(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL %s: got %h want %h", n, o, e); end

    // Held start in OCIOSO: exactly one serve.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    start = 1'b1;
    rb_cnt = 0; saque_cnt = 0; prev = estado;
    exp_q.push_back(mk(2, 0, 0, 1, 0, 1, 0, 0)); nm_q.push_back("held_start_state");
    for (int i = 0; i < 100; i++) begin
      tick();
      if (reset_bola === 1'b1) rb_cnt++;
      if (estado === 3'd1 && prev !== 3'd1) saque_cnt++;
      prev = estado;
    end
    start = 1'b0;
    ntests++;
    if (rb_cnt !== 1) begin nfail++; $display("FAIL held_start_reset_bola: got %0d want 1", rb_cnt); end
    ntests++;
    if (saque_cnt !== 1) begin nfail++; $display("FAIL held_start_saque_entries: got %0d want 1", saque_cnt); end
    e = exp_q.pop_front(); n = nm_q.pop_front(); o = sample(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL %s: got %h want %h", n, o, e); end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    string n;
    begin_match();
    goal_and_wait(1'b0, 1'b1);
    goal_and_wait(1'b1, 1'b0);
    gol_dir = 1'b1;
    exp_q.push_back(mk(3, 2, 1, 0, 1, 1, 0, 0)); nm_q.push_back("score_2_1");
    tick();
    gol_dir = 1'b0;
    e = exp_q.pop_front(); n = nm_q.pop_front(); o = sample(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL %s: got %h want %h", n, o, e); end
    tick();
    reset = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0)); nm_q.push_back("async_reset_mid_ponto");
    #1;
    e = exp_q.pop_front(); n = nm_q.pop_front(); o = sample(); ntests++;
    if (o !== e) begin nfail++; $display("FAIL %s: got %h want %h", n, o, e); end
    tick();
    reset = 1'b0;
    tick();
  endtask

`ifdef CONTROLE_PARTIDA_VANTAGEM_EN
  task automatic test_vantagem();
    obs_t e, o;
    string n;
    begin_match();
    goal_and_wait(1'b0, 1'b1);
    goal_and_wait(1'b0, 1'b1);
    goal_and_wait(1'b1, 1'b0);
    goal_and_wait(1'b1, 1'b0);
    exp_q.push_back(mk(3, 3, 2, 0, 1, 1, 0, 0)); nm_q.push_back("vantagem_3_2_continues");
    exp_q.push_back(mk(4, 4, 2, 0, 1, 1, 1, 0)); nm_q.push_back("vantagem_4_2_wins");
    for (int i = 0; i < 2; i++) begin
      gol_dir = 1'b1;
      tick();
      gol_dir = 1'b0;
      e = exp_q.pop_front(); n = nm_q.pop_front(); o = sample(); ntests++;
      if (o !== e) begin nfail++; $display("FAIL %s: got %h want %h", n, o, e); end
      repeat (4) tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start_serve();
    test_goal_dir();
    test_simultaneous();
    test_win();
    test_goal_ignored();
    test_reset_mid();
`ifdef CONTROLE_PARTIDA_VANTAGEM_EN
    test_vantagem();
`endif
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/controle_partida.md
Name: controle_partida

Overview:
Match-control FSM for the pong design. It consumes goal events from the ball-motion logic and drives that logic's `running` gate and ball re-serve pulse. It keeps both players' scores and feeds them straight to the score display. It also detects end of game and waits for a new start press.

Parameters:
PONTOS_VITORIA, 5, score that wins the match (1..15)
PAUSA_CICLOS, 25000000, VGA_CLK cycles of pause before serve and after each point (>=1; 1 s at 25 MHz)

Ports:
VGA_CLK  input  1  clock, all logic rising-edge
reset  input  1  asynchronous, active-high; clock VGA_CLK
start  input  1  level, active-high start request (already inverted from KEY); internally rising-edge detected
gol_esq  input  1  1-cycle pulse: ball hit left wall; right player scores
gol_dir  input  1  1-cycle pulse: ball hit right wall; left player scores
running  output  1  ball may move; high only in JOGO
reset_bola  output  1  1-cycle pulse: ball logic re-centres ball and takes sentido_saque
sentido_saque  output  1  serve direction, 1 = right, 0 = left
placar_esq  output  4  left player score, binary
placar_dir  output  4  right player score, binary
fim_de_jogo  output  1  1-cycle pulse on entering FIM
vencedor  output  1  0 = left won, 1 = right won; valid in FIM
estado  output  3  current state code (debug/LEDs)

Behaviour:
- Reset (async, any time, including mid-pause or mid-rally):
  - state OCIOSO, counter 0, start edge register 0.
  - running 0, reset_bola 0, sentido_saque 1, scores 0, fim_de_jogo 0, vencedor 0.
- start edge: `start_r` is registered every cycle. Event when start=1 and start_r=0. A held start produces one event only.
- States and codes: OCIOSO=0, SAQUE=1, JOGO=2, PONTO=3, FIM=4. Codes 5-7 are illegal and go to OCIOSO on the next cycle.
- OCIOSO:
  - start event -> SAQUE, clear scores, sentido_saque<=1, pulse reset_bola, counter<=0.
- SAQUE:
  - counter increments each cycle (32-bit).
  - When counter==PAUSA_CICLOS-1 -> JOGO, counter<=0.
  - Net effect: exactly PAUSA_CICLOS cycles in SAQUE; running rises on the following cycle edge.
- JOGO:
  - running=1, combinational from state.
  - gol_esq: placar_dir+1, sentido_saque<=0, pulse reset_bola.
  - gol_dir: placar_esq+1, sentido_saque<=1, pulse reset_bola.
  - gol_esq and gol_dir in the same cycle: gol_esq wins; gol_dir is ignored.
  - After a goal: if the updated score meets the win rule -> FIM, pulse fim_de_jogo, vencedor<=scoring side. Otherwise -> PONTO, counter<=0.
  - start is ignored in JOGO.
- PONTO:
  - running 0. Counts PAUSA_CICLOS cycles exactly as in SAQUE, then -> JOGO.
  - Goal pulses are ignored.
- FIM:
  - running 0. Scores and vencedor hold.
  - start event -> SAQUE with the same actions as from OCIOSO.
- Goals outside JOGO: no score change, no reset_bola.
- Score arithmetic: saturates at 15, never wraps.
- Win rule (default): scoring side's new score == PONTOS_VITORIA.
- Registered outputs change one cycle after the triggering input: scores, reset_bola, fim_de_jogo, vencedor, sentido_saque.

Optional Feature:
Macro CONTROLE_PARTIDA_VANTAGEM_EN.
- Defined: win rule becomes score >= PONTOS_VITORIA and score - other score >= 2. A score reaching 15 also wins regardless of lead (saturation guard).
- Undefined: default win rule above.

Test Plan:
Use PONTOS_VITORIA=3 and PAUSA_CICLOS=4 for all scenarios.
1. Reset, then start rising -> next cycle estado=1, reset_bola pulses once, scores 0. running=0 for 4 cycles, then running=1 and estado=2.
2. In JOGO, pulse gol_dir -> placar_esq=1, sentido_saque=1, reset_bola 1 cycle, estado=3. running=0 for 4 cycles, then back to 2.
3. gol_esq and gol_dir in the same cycle in JOGO -> placar_dir=1, placar_esq unchanged, sentido_saque=0.
4. Three gol_esq rallies -> on the third, placar_dir=3, fim_de_jogo 1-cycle pulse, vencedor=1, estado=4. Further goal pulses leave scores 3/0. Start press -> scores 0, estado=1.
5. Goal pulse during SAQUE/PONTO, and start held high for 100 cycles in OCIOSO -> no score change; only one SAQUE entry.
6. Assert reset mid-PONTO with scores 2/1 -> outputs immediately at reset values, estado=0. With CONTROLE_PARTIDA_VANTAGEM_EN, scores 3-2 do not end the game and 4-2 does.
